// File: rtl/mem_responder_pkg.sv
// Shared types for the multi-channel fixed-latency memory responder.
package mem_responder_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} chan_state_t;
   typedef enum logic {OP_RD, OP_WR} mem_op_t;

endpackage

// File: rtl/mem_responder_channel.sv
// One request channel: accepts a read or write, counts out the fixed latency,
// strobes the storage access on the edge that enters RESP, then holds ready.
//
//   state | meaning
//   IDLE  | waiting for read_valid / write_valid
//   BUSY  | request latched, latency counter running down
//   RESP  | ready asserted, held until the matching valid drops
module mem_responder_channel
   import mem_responder_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8,
   parameter int LATENCY   = 2,
   parameter int WRITABLE  = 1
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 read_valid,
   input  logic [ADDR_BITS-1:0] read_address,
   input  logic                 write_valid,
   input  logic [ADDR_BITS-1:0] write_address,
   input  logic [DATA_BITS-1:0] write_data,
   output logic                 read_ready,
   output logic                 write_ready,
   output logic                 capture,
   output logic                 commit,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [DATA_BITS-1:0] mem_wdata
);

   localparam int CNT_BITS = $clog2(LATENCY + 1);
   localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY);
   localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

   chan_state_t          state_q, state_d;
   mem_op_t              op_q, op_d;
   logic [CNT_BITS-1:0]  cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 wr_req;
   logic                 done;

   assign wr_req = (WRITABLE != 0) && write_valid;
   // terminal count: this edge takes the counter 1 -> 0 and enters RESP
   assign done   = (state_q == BUSY) && (cnt_q == CNT_ONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= OP_RD;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (read_valid) begin
               op_d    = OP_RD;
               addr_d  = read_address;
               cnt_d   = CNT_LOAD;
               state_d = BUSY;
            end else if (wr_req) begin
               op_d    = OP_WR;
               addr_d  = write_address;
               data_d  = write_data;
               cnt_d   = CNT_LOAD;
               state_d = BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_ONE;
            if (done) state_d = RESP;
         end
         RESP: begin
            if ((op_q == OP_RD) ? !read_valid : !write_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign read_ready  = (state_q == RESP) && (op_q == OP_RD);
   assign write_ready = (WRITABLE != 0) && (state_q == RESP) && (op_q == OP_WR);
   assign capture     = done && (op_q == OP_RD);
   assign commit      = done && (op_q == OP_WR);
   assign mem_addr    = addr_q;
   assign mem_wdata   = data_q;

endmodule

// File: rtl/mem_responder.sv
// Multi-channel fixed-latency memory responder: independent request channels
// sharing one un-reset storage array with a backdoor preload port.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8,
   parameter int CHANNELS  = 4,
   parameter int LATENCY   = 2,
   parameter int WRITABLE  = 1
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          load_en,
   input  logic [ADDR_BITS-1:0]          load_addr,
   input  logic [DATA_BITS-1:0]          load_data,
   input  logic [CHANNELS-1:0]           read_valid,
   input  logic [CHANNELS*ADDR_BITS-1:0] read_address,
   output logic [CHANNELS-1:0]           read_ready,
   output logic [CHANNELS*DATA_BITS-1:0] read_data,
   input  logic [CHANNELS-1:0]           write_valid,
   input  logic [CHANNELS*ADDR_BITS-1:0] write_address,
   input  logic [CHANNELS*DATA_BITS-1:0] write_data,
   output logic [CHANNELS-1:0]           write_ready
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [CHANNELS-1:0]  capture;
   logic [CHANNELS-1:0]  commit;
   logic [ADDR_BITS-1:0] ch_addr  [CHANNELS];
   logic [DATA_BITS-1:0] ch_wdata [CHANNELS];
   logic [DATA_BITS-1:0] rdata_q  [CHANNELS];

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      mem_responder_channel #(
         .ADDR_BITS (ADDR_BITS),
         .DATA_BITS (DATA_BITS),
         .LATENCY   (LATENCY),
         .WRITABLE  (WRITABLE)
      ) u_chan (
         .clk           (clk),
         .reset         (reset),
         .read_valid    (read_valid[i]),
         .read_address  (read_address[i*ADDR_BITS +: ADDR_BITS]),
         .write_valid   (write_valid[i]),
         .write_address (write_address[i*ADDR_BITS +: ADDR_BITS]),
         .write_data    (write_data[i*DATA_BITS +: DATA_BITS]),
         .read_ready    (read_ready[i]),
         .write_ready   (write_ready[i]),
         .capture       (capture[i]),
         .commit        (commit[i]),
         .mem_addr      (ch_addr[i]),
         .mem_wdata     (ch_wdata[i])
      );
      assign read_data[i*DATA_BITS +: DATA_BITS] = rdata_q[i];
   end

   // Later assignments win: channel 0 lands after higher channels, preload lands last.
   always_ff @(posedge clk) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (commit[i]) mem[ch_addr[i]] <= ch_wdata[i];
      end
      if (load_en) mem[load_addr] <= load_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) rdata_q[i] <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (capture[i]) rdata_q[i] <= mem[ch_addr[i]];
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, hand-written corner
// sequences and randomized traffic against an array model of the storage.
module tb_mem_responder;

   localparam int AB  = 8;
   localparam int DB  = 8;
   localparam int CH  = 4;
   localparam int LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic             load_en;
   logic [AB-1:0]    load_addr;
   logic [DB-1:0]    load_data;
   logic [CH-1:0]    read_valid, read_ready, write_valid, write_ready;
   logic [CH*AB-1:0] read_address, write_address;
   logic [CH*DB-1:0] read_data, write_data;

   logic             ro_load_en;
   logic [AB-1:0]    ro_load_addr;
   logic [DB-1:0]    ro_load_data;
   logic [CH-1:0]    ro_read_valid, ro_read_ready, ro_write_valid, ro_write_ready;
   logic [CH*AB-1:0] ro_read_address, ro_write_address;
   logic [CH*DB-1:0] ro_read_data, ro_write_data;

   mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .CHANNELS(CH), .LATENCY(LAT), .WRITABLE(1)) dut (
      .clk(clk), .reset(reset),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .read_valid(read_valid), .read_address(read_address),
      .read_ready(read_ready), .read_data(read_data),
      .write_valid(write_valid), .write_address(write_address),
      .write_data(write_data), .write_ready(write_ready)
   );

   mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .CHANNELS(CH), .LATENCY(1), .WRITABLE(0)) dut_ro (
      .clk(clk), .reset(reset),
      .load_en(ro_load_en), .load_addr(ro_load_addr), .load_data(ro_load_data),
      .read_valid(ro_read_valid), .read_address(ro_read_address),
      .read_ready(ro_read_ready), .read_data(ro_read_data),
      .write_valid(ro_write_valid), .write_address(ro_write_address),
      .write_data(ro_write_data), .write_ready(ro_write_ready)
   );

   logic [DB-1:0] model [256];
   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      bit            is_wr;
      int            ch;
      logic [AB-1:0] addr;
      logic [DB-1:0] data;
      logic [DB-1:0] exp;
      int            hold;
      string         name;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic rd(input int ch, input logic [AB-1:0] a, input logic [DB-1:0] exp,
                     input int hold, input string name);
      logic early;
      early = 1'b0;
      @(negedge clk);
      read_valid[ch] = 1'b1;
      read_address[ch*AB +: AB] = a;
      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         if (read_ready[ch]) early = 1'b1;
      end
      chk({name, "_early"}, early, 0);
      for (int k = 0; k <= hold; k++) begin
         @(negedge clk);
         chk({name, "_ready"}, read_ready[ch], 1);
         chk({name, "_data"}, read_data[ch*DB +: DB], exp);
      end
      read_valid[ch] = 1'b0;
      @(negedge clk);
      chk({name, "_release"}, read_ready[ch], 0);
      chk({name, "_kept"}, read_data[ch*DB +: DB], exp);
   endtask

   task automatic wr(input int ch, input logic [AB-1:0] a, input logic [DB-1:0] d,
                     input int hold, input string name);
      logic early;
      early = 1'b0;
      @(negedge clk);
      write_valid[ch] = 1'b1;
      write_address[ch*AB +: AB] = a;
      write_data[ch*DB +: DB] = d;
      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         if (write_ready[ch]) early = 1'b1;
      end
      chk({name, "_early"}, early, 0);
      for (int k = 0; k <= hold; k++) begin
         @(negedge clk);
         chk({name, "_ready"}, write_ready[ch], 1);
      end
      write_valid[ch] = 1'b0;
      @(negedge clk);
      chk({name, "_release"}, write_ready[ch], 0);
      model[a] = d;
   endtask

   // several channels write one address on the same edge; lowest channel should win
   task automatic multi_wr(input logic [CH-1:0] mask, input logic [AB-1:0] a, input string name);
      logic [DB-1:0] d [CH];
      int winner;
      winner = -1;
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
         d[i] = DB'($urandom_range(0, 255));
         if (mask[i]) begin
            write_address[i*AB +: AB] = a;
            write_data[i*DB +: DB] = d[i];
            if (winner < 0) winner = i;
         end
      end
      write_valid = mask;
      repeat (LAT) @(negedge clk);
      @(negedge clk);
      chk({name, "_ready"}, write_ready, mask);
      write_valid = '0;
      @(negedge clk);
      model[a] = d[winner];
      rd(CH - 1, a, model[a], 0, {name, "_readback"});
   endtask

   initial begin
      logic flag;
      logic [7:0] a, d;
      reset = 1'b1;
      load_en = 0; load_addr = '0; load_data = '0;
      read_valid = '0; read_address = '0; write_valid = '0; write_address = '0; write_data = '0;
      ro_load_en = 0; ro_load_addr = '0; ro_load_data = '0;
      ro_read_valid = '0; ro_read_address = '0; ro_write_valid = '0;
      ro_write_address = '0; ro_write_data = '0;

      vecs[0] = '{0, 0, 8'd0,   8'd0,    8'd42,   3, "t1_rd_addr0"};
      vecs[1] = '{1, 1, 8'd5,   8'd99,   8'd0,    0, "t2_wr_addr5"};
      vecs[2] = '{0, 1, 8'd5,   8'd0,    8'd99,   0, "t2_rd_addr5"};
      vecs[3] = '{0, 3, 8'd200, 8'd0,    8'd200,  1, "rd_addr200"};
      vecs[4] = '{1, 2, 8'd255, 8'hA5,   8'd0,    2, "wr_addr255"};
      vecs[5] = '{0, 0, 8'd255, 8'd0,    8'hA5,   0, "rd_addr255"};
      vecs[6] = '{0, 2, 8'd1,   8'd0,    8'd1,    0, "rd_addr1"};

      repeat (2) @(negedge clk);
      chk("reset_read_ready", read_ready, 0);
      chk("reset_write_ready", write_ready, 0);
      chk("reset_read_data", read_data, 0);
      chk("reset_ro_write_ready", ro_write_ready, 0);

      // storage has no reset, so preload works even while reset is held
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         load_en = 1'b1; load_addr = AB'(i); load_data = DB'(i);
         model[i] = DB'(i);
      end
      @(negedge clk);
      load_en = 1'b1; load_addr = 8'd0; load_data = 8'd42; model[0] = 8'd42;
      @(negedge clk);
      load_en = 1'b0;
      reset = 1'b0;

      for (int v = 0; v < 7; v++) begin
         if (vecs[v].is_wr) wr(vecs[v].ch, vecs[v].addr, vecs[v].data, vecs[v].hold, vecs[v].name);
         else rd(vecs[v].ch, vecs[v].addr, vecs[v].exp, vecs[v].hold, vecs[v].name);
      end

      // same-address writes from ch0 and ch2 on one edge
      @(negedge clk);
      write_address[0*AB +: AB] = 8'd7; write_data[0*DB +: DB] = 8'd11;
      write_address[2*AB +: AB] = 8'd7; write_data[2*DB +: DB] = 8'd22;
      write_valid = 4'b0101;
      repeat (LAT + 1) @(negedge clk);
      chk("t3_ready", write_ready, 4'b0101);
      write_valid = '0;
      @(negedge clk);
      model[7] = 8'd11;
      rd(3, 8'd7, 8'd11, 0, "t3_readback");

      // read capture and write commit to the same address on one edge
      @(negedge clk);
      read_address[0*AB +: AB] = 8'd3; read_valid[0] = 1'b1;
      write_address[1*AB +: AB] = 8'd3; write_data[1*DB +: DB] = 8'd8; write_valid[1] = 1'b1;
      repeat (LAT + 1) @(negedge clk);
      chk("t4_rd_ready", read_ready[0], 1);
      chk("t4_wr_ready", write_ready[1], 1);
      chk("t4_old_data", read_data[0*DB +: DB], 3);
      read_valid[0] = 1'b0; write_valid[1] = 1'b0;
      @(negedge clk);
      model[3] = 8'd8;
      rd(0, 8'd3, 8'd8, 0, "t4_new_data");

      // reset while ch2 is in RESP and ch1's write to addr9 is still BUSY
      @(negedge clk);
      read_address[2*AB +: AB] = 8'd10; read_valid[2] = 1'b1;
      @(negedge clk);
      write_address[1*AB +: AB] = 8'd9; write_data[1*DB +: DB] = 8'd77; write_valid[1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t5_pre_ready", read_ready[2], 1);
      reset = 1'b1;
      #1;
      chk("t5_read_ready", read_ready, 0);
      chk("t5_write_ready", write_ready, 0);
      chk("t5_read_data", read_data, 0);
      read_valid = '0; write_valid = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      rd(1, 8'd9, 8'd9, 0, "t5_addr9_kept");

      // read wins over a simultaneous write; the write is served afterwards
      @(negedge clk);
      read_address[2*AB +: AB] = 8'd30; write_address[2*AB +: AB] = 8'd30;
      write_data[2*DB +: DB] = 8'h33;
      read_valid[2] = 1'b1; write_valid[2] = 1'b1;
      repeat (LAT + 1) @(negedge clk);
      chk("rw_read_ready", read_ready[2], 1);
      chk("rw_write_ready", write_ready[2], 0);
      chk("rw_old_data", read_data[2*DB +: DB], 30);
      read_valid[2] = 1'b0;
      @(negedge clk);
      chk("rw_read_release", read_ready[2], 0);
      flag = 1'b0;
      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         if (write_ready[2]) flag = 1'b1;
      end
      chk("rw_write_early", flag, 0);
      @(negedge clk);
      chk("rw_write_ready_late", write_ready[2], 1);
      write_valid[2] = 1'b0;
      @(negedge clk);
      model[30] = 8'h33;
      rd(2, 8'd30, 8'h33, 0, "rw_readback");

      // write valid dropped during BUSY: one-cycle ready, still commits
      @(negedge clk);
      write_address[3*AB +: AB] = 8'd40; write_data[3*DB +: DB] = 8'h44; write_valid[3] = 1'b1;
      @(negedge clk);
      write_valid[3] = 1'b0;
      @(negedge clk);
      chk("drop_wr_busy", write_ready[3], 0);
      @(negedge clk);
      chk("drop_wr_pulse", write_ready[3], 1);
      @(negedge clk);
      chk("drop_wr_end", write_ready[3], 0);
      model[40] = 8'h44;
      rd(3, 8'd40, 8'h44, 0, "drop_wr_readback");

      // read valid dropped during BUSY
      @(negedge clk);
      read_address[0*AB +: AB] = 8'd41; read_valid[0] = 1'b1;
      @(negedge clk);
      read_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("drop_rd_pulse", read_ready[0], 1);
      chk("drop_rd_data", read_data[0*DB +: DB], 41);
      @(negedge clk);
      chk("drop_rd_end", read_ready[0], 0);

      // preload on the commit edge overrides the channel write
      @(negedge clk);
      write_address[1*AB +: AB] = 8'd20; write_data[1*DB +: DB] = 8'd5; write_valid[1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      load_en = 1'b1; load_addr = 8'd20; load_data = 8'd6;
      @(negedge clk);
      load_en = 1'b0;
      chk("load_ovr_ready", write_ready[1], 1);
      write_valid[1] = 1'b0;
      @(negedge clk);
      model[20] = 8'd6;
      rd(0, 8'd20, 8'd6, 0, "load_ovr_readback");

      // randomized traffic against the array model
      for (int it = 0; it < 40; it++) begin
         a = AB'($urandom_range(0, 255));
         d = DB'($urandom_range(0, 255));
         case ($urandom_range(0, 3))
            0: rd($urandom_range(0, CH - 1), a, model[a], $urandom_range(0, 2), "rnd_rd");
            1: wr($urandom_range(0, CH - 1), a, d, $urandom_range(0, 2), "rnd_wr");
            2: multi_wr(CH'($urandom_range(1, 15)), a, "rnd_multi");
            default: begin
               @(negedge clk);
               load_en = 1'b1; load_addr = a; load_data = d;
               @(negedge clk);
               load_en = 1'b0;
               model[a] = d;
               rd($urandom_range(0, CH - 1), a, d, 0, "rnd_load_rd");
            end
         endcase
      end

      // read-only instance with latency 1
      @(negedge clk);
      ro_load_en = 1'b1; ro_load_addr = 8'd1; ro_load_data = 8'h5A;
      @(negedge clk);
      ro_load_en = 1'b0;
      ro_write_address[0*AB +: AB] = 8'd1; ro_write_data[0*DB +: DB] = 8'hFF;
      ro_write_valid[0] = 1'b1;
      flag = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (ro_write_ready[0]) flag = 1'b1;
      end
      chk("t6_write_ready", flag, 0);
      ro_read_address[0*AB +: AB] = 8'd1; ro_read_valid[0] = 1'b1;
      @(negedge clk);
      chk("t6_early", ro_read_ready[0], 0);
      @(negedge clk);
      chk("t6_ready", ro_read_ready[0], 1);
      chk("t6_data", ro_read_data[0*DB +: DB], 8'h5A);
      ro_read_valid[0] = 1'b0;
      ro_write_valid[0] = 1'b0;
      @(negedge clk);
      chk("t6_release", ro_read_ready[0], 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
